// File: rtl/fa_stim_pkg.sv
// Shared types and golden full-adder functions for the full-adder stimulus driver.
package fa_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXH  = 2'd1,
    ST_RND  = 2'd2,
    ST_DONE = 2'd3
  } fa_state_t;

  localparam int         VEC_W   = 3;
  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic logic fa_exp_sum(input logic [VEC_W-1:0] vec);
    return ^vec;
  endfunction

  function automatic logic fa_exp_cout(input logic [VEC_W-1:0] vec);
    return (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/fa_stim_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for the random phase; used only
// when FA_STIM_RANDOM_EN is defined.
module fa_stim_lfsr
  import fa_stim_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_adv,
  output logic [VEC_W-1:0] o_vec
);

  logic [7:0] r_state;
  logic       w_fb;

  assign w_fb  = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
  assign o_vec = r_state[VEC_W-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_state <= SEED;
    else if (i_load) r_state <= SEED;
    else if (i_adv)  r_state <= {r_state[6:0], w_fb};
  end

endmodule

// File: rtl/full_adder_stim_driver.sv
// Drives all eight a/b/cin combinations into a full adder and scores its
// responses. Optional random phase is enabled with FA_STIM_RANDOM_EN.
module full_adder_stim_driver
  import fa_stim_pkg::*;
#(
  parameter int         LAT       = 0,
  parameter int         N_RANDOM  = 16,
  parameter logic [7:0] RAND_SEED = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_a,
  output logic             o_b,
  output logic             o_cin,
  input  logic             i_sum,
  input  logic             i_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [7:0]       o_err_count,
  output logic             o_first_err_valid,
  output logic [VEC_W-1:0] o_first_err_vec
);

  localparam logic [3:0] SLOT_LAST = 4'(LAT);

  fa_state_t        r_state, w_next;
  logic [VEC_W-1:0] r_vec;
  logic [3:0]       r_slot;
  logic [7:0]       r_err;
  logic             r_fev;
  logic [VEC_W-1:0] r_fvec;
  logic [VEC_W-1:0] w_vec;
  logic             w_busy;
  logic             w_accept;
  logic             w_slot_end;
  logic             w_mismatch;

`ifdef FA_STIM_RANDOM_EN
  logic [7:0]       r_rnd;
  logic [VEC_W-1:0] w_lfsr_vec;

  fa_stim_lfsr #(.SEED(RAND_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_accept),
    .i_adv   (w_slot_end && (r_state == ST_RND)),
    .o_vec   (w_lfsr_vec)
  );

  assign w_vec = (r_state == ST_RND) ? w_lfsr_vec : r_vec;
`else
  assign w_vec = r_vec;
`endif

  assign w_busy     = (r_state == ST_EXH) || (r_state == ST_RND);
  assign w_accept   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_slot_end = w_busy && (r_slot == 4'd0);
  assign w_mismatch = (i_sum != fa_exp_sum(w_vec)) || (i_cout != fa_exp_cout(w_vec));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    o_a               = 1'b0;
    o_b               = 1'b0;
    o_cin             = 1'b0;
    o_busy            = w_busy;
    o_done            = (r_state == ST_DONE);
    o_pass            = (r_state == ST_DONE) && (r_err == 8'd0);
    o_err_count       = r_err;
    o_first_err_valid = r_fev;
    o_first_err_vec   = r_fvec;
    if (w_busy) {o_a, o_b, o_cin} = w_vec;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_next = ST_EXH;
      ST_EXH: begin
        if (w_slot_end && (r_vec == 3'd7)) begin
`ifdef FA_STIM_RANDOM_EN
          w_next = ST_RND;
`else
          w_next = ST_DONE;
`endif
        end
      end
      ST_RND: begin
`ifdef FA_STIM_RANDOM_EN
        if (w_slot_end && (r_rnd == 8'd0)) w_next = ST_DONE;
`else
        w_next = ST_IDLE;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Slot timer counts down from LAT; the compare fires on its terminal count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vec  <= '0;
      r_slot <= '0;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_fvec <= '0;
`ifdef FA_STIM_RANDOM_EN
      r_rnd  <= '0;
`endif
    end else if (w_accept) begin
      r_vec  <= '0;
      r_slot <= SLOT_LAST;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_fvec <= '0;
`ifdef FA_STIM_RANDOM_EN
      r_rnd  <= 8'(N_RANDOM - 1);
`endif
    end else if (w_slot_end) begin
      r_slot <= SLOT_LAST;
      r_vec  <= r_vec + 3'd1;
      if (w_mismatch) begin
        if (r_err != ERR_MAX) r_err <= r_err + 8'd1;
        if (!r_fev) begin
          r_fev  <= 1'b1;
          r_fvec <= w_vec;
        end
      end
`ifdef FA_STIM_RANDOM_EN
      if (r_state == ST_RND) r_rnd <= r_rnd - 8'd1;
`endif
    end else if (w_busy) begin
      r_slot <= r_slot - 4'd1;
    end
  end

endmodule

// File: tb/tb_full_adder_stim_driver.sv
// Self-checking bench: LAT=0 and LAT=2 drivers against behavioural adder models
// with injectable per-vector faults.
module tb_full_adder_stim_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // LAT=0 driver signals
  logic       rst0, start0, a0, b0, c0, s0, co0, busy0, done0, pass0, fev0;
  logic [7:0] err0;
  logic [2:0] fvec0;
  logic [7:0] fs0 = '0, fc0 = '0;
  logic       mode0 = 1'b0;
  logic [1:0] p0_1 = '0, p0_2 = '0;

  // LAT=2 driver signals
  logic       rst2, start2, a2, b2, c2, s2, co2, busy2, done2, pass2, fev2;
  logic [7:0] err2;
  logic [2:0] fvec2;
  logic [7:0] fs2 = '0, fc2 = '0;
  logic [1:0] p2_1 = '0, p2_2 = '0;

  function automatic logic g_sum(input logic [2:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  function automatic logic g_cout(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  full_adder_stim_driver #(.LAT(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst0), .i_start(start0),
    .o_a(a0), .o_b(b0), .o_cin(c0), .i_sum(s0), .i_cout(co0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0),
    .o_first_err_valid(fev0), .o_first_err_vec(fvec0)
  );

  full_adder_stim_driver #(.LAT(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst2), .i_start(start2),
    .o_a(a2), .o_b(b2), .o_cin(c2), .i_sum(s2), .i_cout(co2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_count(err2),
    .o_first_err_valid(fev2), .o_first_err_vec(fvec2)
  );

  // Adder models: faulty combinational (flip masks per vector) or 2-cycle pipelined.
  always_ff @(posedge clk) begin
    p0_1 <= {g_sum({a0, b0, c0}), g_cout({a0, b0, c0})};
    p0_2 <= p0_1;
    p2_1 <= {g_sum({a2, b2, c2}) ^ fs2[{a2, b2, c2}], g_cout({a2, b2, c2}) ^ fc2[{a2, b2, c2}]};
    p2_2 <= p2_1;
  end

  always_comb begin
    if (mode0) {s0, co0} = p0_2;
    else begin
      s0  = g_sum({a0, b0, c0}) ^ fs0[{a0, b0, c0}];
      co0 = g_cout({a0, b0, c0}) ^ fc0[{a0, b0, c0}];
    end
    {s2, co2} = p2_2;
  end

  always @(negedge clk) begin
    if (!rst0) begin
      n_checks++;
      if (busy0 && done0) begin n_fail++; $display("FAIL busy_done_excl0 busy=%0b done=%0b", busy0, done0); end
    end
    if (!rst2) begin
      n_checks++;
      if (busy2 && done2) begin n_fail++; $display("FAIL busy_done_excl2 busy=%0b done=%0b", busy2, done2); end
    end
  end

  task automatic run0(output int cyc);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!done0 && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  task automatic run2(output int cyc);
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!done2 && cyc < 400) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0} !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs0 got=%h exp=0", {a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0});
    end
    n_checks++;
    if ({a2, b2, c2, busy2, done2, pass2, err2, fev2, fvec2} !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs2 got=%h exp=0", {a2, b2, c2, busy2, done2, pass2, err2, fev2, fvec2});
    end
    rst0 = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lat0_exhaustive;
    fs0 = '0; fc0 = '0; mode0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a0, b0, c0} !== 3'(i) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        n_fail++; $display("FAIL lat0_vec cyc=%0d got vec=%0d busy=%0b done=%0b exp vec=%0d busy=1 done=0",
                           i, {a0, b0, c0}, busy0, done0, i);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || {a0, b0, c0} !== 3'd0) begin
      n_fail++; $display("FAIL lat0_done got done=%0b busy=%0b vec=%0d exp 1 0 0", done0, busy0, {a0, b0, c0});
    end
    n_checks++;
    if (err0 !== 8'd0 || pass0 !== 1'b1 || fev0 !== 1'b0) begin
      n_fail++; $display("FAIL lat0_result got err=%0d pass=%0b fev=%0b exp 0 1 0", err0, pass0, fev0);
    end
  endtask

  task automatic test_stuck_sum;
    int cyc;
    fc0 = '0;
    for (int v = 0; v < 8; v++) fs0[v] = g_sum(3'(v));
    run0(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL stuck_latency got=%0d exp=8", cyc); end
    n_checks++;
    if (err0 !== 8'd4 || fvec0 !== 3'b001 || fev0 !== 1'b1 || pass0 !== 1'b0) begin
      n_fail++; $display("FAIL stuck_sum got err=%0d fvec=%b fev=%0b pass=%0b exp 4 001 1 0", err0, fvec0, fev0, pass0);
    end
    fs0 = '0;
  endtask

  task automatic test_cout_inverted;
    int cyc;
    fs0 = '0; fc0 = 8'hFF;
    run0(cyc);
    n_checks++;
    if (err0 !== 8'd8 || fvec0 !== 3'b000 || fev0 !== 1'b1 || pass0 !== 1'b0 || cyc !== 8) begin
      n_fail++; $display("FAIL cout_inv got err=%0d fvec=%b fev=%0b pass=%0b cyc=%0d exp 8 000 1 0 8",
                         err0, fvec0, fev0, pass0, cyc);
    end
    fc0 = '0;
  endtask

  task automatic test_random_faults;
    int cyc, exp_err, exp_first;
    for (int it = 0; it < 10; it++) begin
      fs0 = 8'($urandom) & 8'($urandom);
      fc0 = (it % 3 == 0) ? 8'd0 : 8'($urandom) & 8'($urandom);
      if (it == 4) begin fs0 = '0; fc0 = '0; end
      exp_err = 0; exp_first = 0;
      for (int v = 7; v >= 0; v--) if (fs0[v] || fc0[v]) begin exp_err++; exp_first = v; end
      run0(cyc);
      n_checks++;
      if (err0 !== 8'(exp_err) || fev0 !== (exp_err > 0) || pass0 !== (exp_err == 0) || cyc !== 8) begin
        n_fail++; $display("FAIL rand_fault it=%0d got err=%0d fev=%0b pass=%0b cyc=%0d exp err=%0d fev=%0b pass=%0b cyc=8",
                           it, err0, fev0, pass0, cyc, exp_err, exp_err > 0, exp_err == 0);
      end
      if (exp_err > 0) begin
        n_checks++;
        if (fvec0 !== 3'(exp_first)) begin
          n_fail++; $display("FAIL rand_first it=%0d got=%0d exp=%0d", it, fvec0, exp_first);
        end
      end
    end
    fs0 = '0; fc0 = '0;
  endtask

  task automatic test_lat2;
    int cyc, exp_err, exp_first;
    fs2 = '0; fc2 = '0;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      n_checks++;
      if ({a2, b2, c2} !== 3'(n / 3) || busy2 !== 1'b1) begin
        n_fail++; $display("FAIL lat2_hold cyc=%0d got vec=%0d busy=%0b exp vec=%0d busy=1", n, {a2, b2, c2}, busy2, n / 3);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 8'd0) begin
      n_fail++; $display("FAIL lat2_done got done=%0b pass=%0b err=%0d exp 1 1 0", done2, pass2, err2);
    end
    for (int it = 0; it < 4; it++) begin
      fs2 = 8'($urandom) & 8'($urandom);
      fc2 = 8'($urandom) & 8'($urandom);
      exp_err = 0; exp_first = 0;
      for (int v = 7; v >= 0; v--) if (fs2[v] || fc2[v]) begin exp_err++; exp_first = v; end
      repeat (3) @(negedge clk);
      run2(cyc);
      n_checks++;
      if (err2 !== 8'(exp_err) || pass2 !== (exp_err == 0) || cyc !== 24 ||
          (exp_err > 0 && fvec2 !== 3'(exp_first))) begin
        n_fail++; $display("FAIL lat2_rand it=%0d got err=%0d pass=%0b cyc=%0d fvec=%0d exp err=%0d cyc=24 fvec=%0d",
                           it, err2, pass2, cyc, fvec2, exp_err, exp_first);
      end
    end
    fs2 = '0; fc2 = '0;
  endtask

  task automatic test_lat0_on_delayed_dut;
    int cyc, exp_err, exp_first;
    logic [2:0] seen;
    mode0 = 1'b1;
    repeat (3) @(negedge clk);
    exp_err = 0; exp_first = 0;
    // Each compare sees the response to the vector two slots earlier (idle inputs are 0).
    for (int i = 7; i >= 0; i--) begin
      seen = (i >= 2) ? 3'(i - 2) : 3'd0;
      if (g_sum(seen) != g_sum(3'(i)) || g_cout(seen) != g_cout(3'(i))) begin exp_err++; exp_first = i; end
    end
    run0(cyc);
    n_checks++;
    if (err0 === 8'd0 || pass0 !== 1'b0) begin
      n_fail++; $display("FAIL delayed_nonzero got err=%0d pass=%0b exp err!=0 pass=0", err0, pass0);
    end
    n_checks++;
    if (err0 !== 8'(exp_err) || fvec0 !== 3'(exp_first)) begin
      n_fail++; $display("FAIL delayed_exact got err=%0d fvec=%0d exp err=%0d fvec=%0d", err0, fvec0, exp_err, exp_first);
    end
    mode0 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    fc0 = 8'hFF;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = 0;
    @(negedge clk);
    while ({a0, b0, c0} != 3'd5 && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++;
    if ({a0, b0, c0} !== 3'd5 || err0 !== 8'd5) begin
      n_fail++; $display("FAIL pre_reset got vec=%0d err=%0d exp vec=5 err=5", {a0, b0, c0}, err0);
    end
    rst0 = 1'b1;
    #1;
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0} !== 17'd0) begin
      n_fail++; $display("FAIL mid_reset got=%h exp=0", {a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0} !== 17'd0) begin
      n_fail++; $display("FAIL mid_reset_hold got=%h exp=0", {a0, b0, c0, busy0, done0, pass0, err0, fev0, fvec0});
    end
    @(negedge clk); rst0 = 1'b0; fc0 = '0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a0, b0, c0} !== 3'd0 || busy0 !== 1'b1 || err0 !== 8'd0 || fev0 !== 1'b0) begin
      n_fail++; $display("FAIL restart got vec=%0d busy=%0b err=%0d fev=%0b exp 0 1 0 0", {a0, b0, c0}, busy0, err0, fev0);
    end
    cyc = 0;
    while (!done0 && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 8'd0) begin
      n_fail++; $display("FAIL restart_done got done=%0b pass=%0b err=%0d exp 1 1 0", done0, pass0, err0);
    end
  endtask

  task automatic test_start_held;
    int cyc;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      n_checks++;
      if ({a0, b0, c0} !== 3'(n) || busy0 !== 1'b1) begin
        n_fail++; $display("FAIL held_vec cyc=%0d got vec=%0d busy=%0b exp vec=%0d busy=1", n, {a0, b0, c0}, busy0, n);
      end
    end
    start0 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 1'b1) begin
        n_fail++; $display("FAIL held_done cyc=%0d got done=%0b busy=%0b pass=%0b exp 1 0 1", n, done0, busy0, pass0);
      end
    end
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    n_checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || pass0 !== 1'b0) begin
      n_fail++; $display("FAIL rerun_clear got done=%0b busy=%0b pass=%0b exp 0 1 0", done0, busy0, pass0);
    end
    cyc = 0;
    @(negedge clk);
    while (!done0 && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || cyc !== 8) begin
      n_fail++; $display("FAIL rerun_done got done=%0b pass=%0b cyc=%0d exp 1 1 8", done0, pass0, cyc);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
    test_reset;
    test_lat0_exhaustive;
    test_stuck_sum;
    test_cout_inverted;
    test_random_faults;
    test_lat2;
    test_lat0_on_delayed_dut;
    test_reset_mid_run;
    test_start_held;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_stim_driver.md
# full_adder_stim_driver

Sequential stimulus driver and scoreboard for the 1-bit `full_adder`. It is the driving end of the same `a`/`b`/`cin` → `sum`/`cout` interface that our formal checkers observe. On `start` it applies all eight input combinations to the DUT and compares the DUT outputs against the golden full-adder function. It counts mismatches and reports pass/fail. It sits in simulation and emulation harnesses beside `full_adder`, whose outputs may be combinational or registered with fixed latency.

## Interface
Parameters:
- `LAT`, 0: DUT output latency in clock cycles (0 = combinational DUT); range 0–15.
- `N_RANDOM`, 16: number of random vectors after the exhaustive phase (only with the macro); range 1–255.
- `RAND_SEED`, 8'hA5: LFSR seed, must be nonzero (only with the macro).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE and DONE.
- `a`, `b`, `cin`  out  1 each  stimulus to DUT.
- `sum`, `cout`  in  1 each  DUT response.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next accepted `start`.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  8  mismatching vectors; saturates at 255.
- `first_err_valid`  out  1  at least one mismatch seen this run.
- `first_err_vec`  out  3  {a,b,cin} of the first mismatching vector.

## Operation
- Vector encoding: vec[2]=a, vec[1]=b, vec[0]=cin.
- Expected `sum` = ^vec. Expected `cout` = majority(vec).
- A vector mismatches if either `sum` or `cout` differs; it counts once even if both differ.
- States:
  - IDLE → EXH when `start`=1.
  - EXH steps vec 0..7 ascending, then → DONE, or → RND with `FA_STIM_RANDOM_EN`.
  - RND → DONE after `N_RANDOM` vectors.
  - DONE → EXH when `start`=1.
- Each vector occupies a slot of LAT+1 cycles. `a`/`b`/`cin` are held constant for the whole slot.
- The compare happens at the final rising edge of each slot, sampling `sum`/`cout` at that edge.
- Accepting `start` clears `err_count`, `first_err_valid`, `first_err_vec` and `done`.
- `first_err_vec` is written only on the first mismatch of a run. Later mismatches leave it unchanged.
- `a`/`b`/`cin` are 0 in IDLE and DONE.
- `start` while busy is ignored; the run is unaffected.
- Reset at any time (including mid-run) forces IDLE and drives all outputs to 0.
- Reset values: `a`=`b`=`cin`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_vec`=0.

## Timing
- `start` sampled high at edge k:
  - after edge k: `busy`=1 and vec 0 is driven.
  - vector i is driven from edge k+i·(LAT+1) to edge k+(i+1)·(LAT+1).
- Exhaustive-only run: after edge k+8·(LAT+1), `busy`=0, `done`=1, `pass` valid, stimulus returns to 0.
  - With LAT=0, `done` rises 8 cycles after start.
- With the macro, the run extends by `N_RANDOM`·(LAT+1) cycles.
- `err_count` and `first_err_*` update at the compare edge, so they are visible the cycle after it.
- `busy` and `done` are never both 1.

## Configuration
- `FA_STIM_RANDOM_EN` defined:
  - RND phase follows EXH.
  - Random source is an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded with `RAND_SEED` on accepted `start` and on reset (reset loads `RAND_SEED` too).
  - The LFSR advances once per slot; vec = lfsr[2:0].
- Not defined:
  - no LFSR logic is present; `N_RANDOM` and `RAND_SEED` are unused.
  - DONE follows vector 7 directly.

## Structure
- Package `fa_stim_pkg`:
  - state enum (IDLE, EXH, RND, DONE);
  - `VEC_W`=3;
  - `ERR_MAX`=255;
  - functions `fa_exp_sum`/`fa_exp_cout` taking a 3-bit vec.
- Sub-module `fa_stim_lfsr` (8-bit, load/advance enables), instantiated only under `FA_STIM_RANDOM_EN`.

## Test plan
- LAT=0, correct DUT, `start` pulse → 8 vectors 000..111 on consecutive cycles; `done`=1 8 cycles after start; `err_count`=0; `pass`=1.
- LAT=2, DUT registered with 2-cycle delay → each vector held 3 cycles; `done` after 24 cycles; `pass`=1. The same DUT with LAT=0 gives `err_count`≠0.
- DUT `sum` stuck at 0 → `err_count`=4 (vectors 1, 2, 4, 7); `first_err_vec`=3'b001; `pass`=0.
- DUT `cout` inverted → `err_count`=8; `first_err_vec`=3'b000.
- `reset` asserted at vector 5, then a new `start` → all outputs 0 during reset; the new run restarts at vec 0 with counters cleared.
- `start` held high for the whole run → a single run completes; a second `start` after `done` clears `done` and reruns.
